// File: rtl/vga_pattern_gen_if.sv
// Pixel-side bundle of the VGA pattern generator.
// master: the generator (takes mode/pause, drives colour, syncs and
// pixel position); slave: whatever consumes the video stream.
// Ports:
//   mode[1:0]  pattern select (0 border, 1 bars, 2 checker, 3 square)
//   pause      freezes the bouncing-square animation
//   r/g/b      colour channels, CW bits each
//   hsync      horizontal sync
//   vsync      vertical sync
//   display_on visible area flag
//   hpos/vpos  coordinates of the pixel currently on the outputs
//   frame_tick one-cycle pulse with pixel (0,0)
interface vga_pattern_gen_if #(
   parameter int CW = 2
);
   logic [1:0]    mode;
   logic          pause;
   logic [CW-1:0] r;
   logic [CW-1:0] g;
   logic [CW-1:0] b;
   logic          hsync;
   logic          vsync;
   logic          display_on;
   logic [9:0]    hpos;
   logic [9:0]    vpos;
   logic          frame_tick;

   modport master (
      input  mode,
      input  pause,
      output r,
      output g,
      output b,
      output hsync,
      output vsync,
      output display_on,
      output hpos,
      output vpos,
      output frame_tick
   );

   modport slave (
      output mode,
      output pause,
      input  r,
      input  g,
      input  b,
      input  hsync,
      input  vsync,
      input  display_on,
      input  hpos,
      input  vpos,
      input  frame_tick
   );
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator.
// Ports:
//   clk    pixel clock
//   rst_n  asynchronous active-low reset
//   vga    master side of vga_pattern_gen_if: mode/pause in;
//          r/g/b, hsync, vsync, display_on, hpos, vpos, frame_tick out.
// Every output is registered one cycle after the hc/vc counters, so
// hpos/vpos always name the pixel shown on r/g/b and the syncs.
module vga_pattern_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int CW       = 2,
   parameter int CHK_LOG2 = 5,
   parameter int SQ_SIZE  = 32
) (
   input logic           clk,
   input logic           rst_n,
   vga_pattern_gen_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] HC_MAX = 10'(H_TOTAL - 1);
   localparam logic [9:0] VC_MAX = 10'(V_TOTAL - 1);
   localparam logic [9:0] HA     = 10'(H_ACTIVE);
   localparam logic [9:0] HA_M1  = 10'(H_ACTIVE - 1);
   localparam logic [9:0] VA     = 10'(V_ACTIVE);
   localparam logic [9:0] VA_M1  = 10'(V_ACTIVE - 1);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] BW_M1  = 10'((H_ACTIVE >> 3) - 1);
   localparam logic [9:0] SX_MAX = 10'(H_ACTIVE - SQ_SIZE);
   localparam logic [9:0] SY_MAX = 10'(V_ACTIVE - SQ_SIZE);
   localparam logic [10:0] SQ    = 11'(SQ_SIZE);

   localparam logic HP = 1'(H_POL);
   localparam logic VP = 1'(V_POL);

   localparam logic [CW-1:0] C_LO  = CW'(1);
   localparam logic [CW-1:0] C_MID = {1'b1, {(CW-1){1'b0}}};
   localparam logic [CW-1:0] C_MAX = '1;

   // raster counters
   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;

   // colour-bar tracker: index of the bar under hc and offset inside it
   logic [2:0] bar_idx_q, bar_idx_d;
   logic [9:0] bar_pix_q, bar_pix_d;

   // pattern actually displayed, latched once per frame
   logic [1:0] mode_q, mode_d;

   // bouncing square: top-left corner and travel direction (1 = +)
   logic [9:0] sx_q, sx_d;
   logic [9:0] sy_q, sy_d;
   logic       dx_q, dx_d;
   logic       dy_q, dy_d;

   // registered outputs
   logic [CW-1:0] r_q, r_d;
   logic [CW-1:0] g_q, g_d;
   logic [CW-1:0] b_q, b_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          de_q, de_d;
   logic [9:0]    hpos_q, hpos_d;
   logic [9:0]    vpos_q, vpos_d;
   logic          ft_q, ft_d;

   logic line_end;
   logic upd;
   logic vis;
   logic in_sq;
   logic chk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc_q      <= '0;
         vc_q      <= '0;
         bar_idx_q <= '0;
         bar_pix_q <= '0;
         mode_q    <= '0;
         sx_q      <= '0;
         sy_q      <= '0;
         dx_q      <= 1'b1;
         dy_q      <= 1'b1;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
         hs_q      <= ~HP;
         vs_q      <= ~VP;
         de_q      <= 1'b0;
         hpos_q    <= '0;
         vpos_q    <= '0;
         ft_q      <= 1'b0;
      end else begin
         hc_q      <= hc_d;
         vc_q      <= vc_d;
         bar_idx_q <= bar_idx_d;
         bar_pix_q <= bar_pix_d;
         mode_q    <= mode_d;
         sx_q      <= sx_d;
         sy_q      <= sy_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         de_q      <= de_d;
         hpos_q    <= hpos_d;
         vpos_q    <= vpos_d;
         ft_q      <= ft_d;
      end
   end

   // raster and bar counters
   always_comb begin
      line_end  = (hc_q == HC_MAX);
      hc_d      = line_end ? 10'd0 : hc_q + 10'd1;
      vc_d      = vc_q;
      bar_idx_d = bar_idx_q;
      bar_pix_d = bar_pix_q + 10'd1;
      if (line_end) begin
         vc_d = (vc_q == VC_MAX) ? 10'd0 : vc_q + 10'd1;
      end
      if (line_end) begin
         bar_idx_d = '0;
         bar_pix_d = '0;
      end else if (bar_pix_q == BW_M1) begin
         bar_pix_d = '0;
         // saturate so leftover pixels past 8*BAR_W stay in bar 7
         if (bar_idx_q != 3'd7) begin
            bar_idx_d = bar_idx_q + 3'd1;
         end
      end
   end

   // frame-rate state: mode latch and square motion, both at the
   // start of the first blanking line so a visible frame never tears
   always_comb begin
      upd    = (hc_q == 10'd0) && (vc_q == VA);
      mode_d = upd ? vga.mode : mode_q;
      sx_d   = sx_q;
      sy_d   = sy_q;
      dx_d   = dx_q;
      dy_d   = dy_q;
      if (upd && !vga.pause) begin
         if (dx_q) begin
            if (sx_q == SX_MAX) begin
               dx_d = 1'b0;
               sx_d = sx_q - 10'd1;
            end else begin
               sx_d = sx_q + 10'd1;
            end
         end else begin
            if (sx_q == 10'd0) begin
               dx_d = 1'b1;
               sx_d = 10'd1;
            end else begin
               sx_d = sx_q - 10'd1;
            end
         end
         if (dy_q) begin
            if (sy_q == SY_MAX) begin
               dy_d = 1'b0;
               sy_d = sy_q - 10'd1;
            end else begin
               sy_d = sy_q + 10'd1;
            end
         end else begin
            if (sy_q == 10'd0) begin
               dy_d = 1'b1;
               sy_d = 10'd1;
            end else begin
               sy_d = sy_q - 10'd1;
            end
         end
      end
   end

   // pixel colour, syncs and position for the current counters
   always_comb begin
      vis   = (hc_q < HA) && (vc_q < VA);
      in_sq = ({1'b0, hc_q} >= {1'b0, sx_q})
           && ({1'b0, hc_q} < {1'b0, sx_q} + SQ)
           && ({1'b0, vc_q} >= {1'b0, sy_q})
           && ({1'b0, vc_q} < {1'b0, sy_q} + SQ);
      chk   = hc_q[CHK_LOG2] ^ vc_q[CHK_LOG2];
      r_d   = '0;
      g_d   = '0;
      b_d   = '0;
      unique case (mode_q)
         2'd0: begin
            if (hc_q == 10'd0) r_d = C_LO;
            else if (hc_q == HA_M1) r_d = C_MAX;
            else r_d = C_MID;
            if (vc_q == 10'd0) g_d = C_LO;
            else if (vc_q == VA_M1) g_d = C_MAX;
            else g_d = C_MID;
         end
         2'd1: begin
            r_d = bar_idx_q[2] ? C_MAX : '0;
            g_d = bar_idx_q[1] ? C_MAX : '0;
            b_d = bar_idx_q[0] ? C_MAX : '0;
         end
         2'd2: begin
            if (chk) begin
               r_d = C_MAX;
               g_d = C_MAX;
               b_d = C_MAX;
            end
         end
         2'd3: begin
            if (in_sq) begin
               r_d = C_MAX;
               g_d = C_MAX;
               b_d = C_MAX;
            end else begin
               b_d = C_MID;
            end
         end
      endcase
      if (!vis) begin
         r_d = '0;
         g_d = '0;
         b_d = '0;
      end
      hs_d   = ((hc_q >= HS_BEG) && (hc_q < HS_END)) ? HP : ~HP;
      vs_d   = ((vc_q >= VS_BEG) && (vc_q < VS_END)) ? VP : ~VP;
      de_d   = vis;
      hpos_d = hc_q;
      vpos_d = vc_q;
      ft_d   = (hc_q == 10'd0) && (vc_q == 10'd0);
   end

   assign vga.r          = r_q;
   assign vga.g          = g_q;
   assign vga.b          = b_q;
   assign vga.hsync      = hs_q;
   assign vga.vsync      = vs_q;
   assign vga.display_on = de_q;
   assign vga.hpos       = hpos_q;
   assign vga.vpos       = vpos_q;
   assign vga.frame_tick = ft_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen on a shrunken raster (45x16 total).
// A pixel model fills a queue on each clock; outputs are popped and
// compared on the falling edge, with directed pattern probes on top.
module tb_vga_pattern_gen;

   localparam int HA  = 36;
   localparam int HF  = 2;
   localparam int HS  = 4;
   localparam int HB  = 3;
   localparam int VA  = 12;
   localparam int VF  = 1;
   localparam int VS  = 2;
   localparam int VB  = 1;
   localparam int CW  = 2;
   localparam int CK  = 2;
   localparam int SQ  = 4;
   localparam int HT  = HA + HF + HS + HB;
   localparam int VT  = VA + VF + VS + VB;
   localparam int FR  = HT * VT;
   localparam int SXM = HA - SQ;
   localparam int SYM = VA - SQ;

   localparam logic [31:0] RST_VAL =
      {2'b0, 6'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   vga_pattern_gen_if #(.CW(CW)) vif ();

   vga_pattern_gen #(
      .H_ACTIVE (HA),
      .H_FP     (HF),
      .H_SYNC   (HS),
      .H_BP     (HB),
      .V_ACTIVE (VA),
      .V_FP     (VF),
      .V_SYNC   (VS),
      .V_BP     (VB),
      .H_POL    (0),
      .V_POL    (0),
      .CW       (CW),
      .CHK_LOG2 (CK),
      .SQ_SIZE  (SQ)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .vga   (vif)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   logic [31:0] obs;
   assign obs = {2'b0, vif.r, vif.g, vif.b, vif.hsync, vif.vsync,
                 vif.display_on, vif.hpos, vif.vpos, vif.frame_tick};

   function automatic logic [31:0] model_px(int h, int v, int md,
                                            int sx, int sy);
      logic [1:0] r, g, b;
      logic       hs, vs, de, ft;
      logic [9:0] hh, vv;
      int         i;
      r  = 2'd0;
      g  = 2'd0;
      b  = 2'd0;
      de = (h < HA) && (v < VA);
      hs = !((h >= HA + HF) && (h < HA + HF + HS));
      vs = !((v >= VA + VF) && (v < VA + VF + VS));
      ft = (h == 0) && (v == 0);
      if (de) begin
         case (md)
            0: begin
               r = (h == 0) ? 2'd1 : ((h == HA - 1) ? 2'd3 : 2'd2);
               g = (v == 0) ? 2'd1 : ((v == VA - 1) ? 2'd3 : 2'd2);
            end
            1: begin
               i = h / (HA / 8);
               if (i > 7) i = 7;
               r = i[2] ? 2'd3 : 2'd0;
               g = i[1] ? 2'd3 : 2'd0;
               b = i[0] ? 2'd3 : 2'd0;
            end
            2: begin
               if ((((h >> CK) ^ (v >> CK)) & 1) == 1) {r, g, b} = 6'h3f;
            end
            default: begin
               if (h >= sx && h < sx + SQ && v >= sy && v < sy + SQ)
                  {r, g, b} = 6'h3f;
               else
                  b = 2'd2;
            end
         endcase
      end
      hh = h[9:0];
      vv = v[9:0];
      return {2'b0, r, g, b, hs, vs, de, hh, vv, ft};
   endfunction

   // reference raster state
   int mh = 0, mv = 0, mmode = 0;
   int msx = 0, msy = 0, mdx = 1, mdy = 1;
   logic [31:0] exp_q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mh = 0; mv = 0; mmode = 0;
         msx = 0; msy = 0; mdx = 1; mdy = 1;
         exp_q.delete();
      end else begin
         exp_q.push_back(model_px(mh, mv, mmode, msx, msy));
         if (mh == 0 && mv == VA) begin
            mmode = int'(vif.mode);
            if (!vif.pause) begin
               if (msx + mdx > SXM || msx + mdx < 0) mdx = -mdx;
               msx += mdx;
               if (msy + mdy > SYM || msy + mdy < 0) mdy = -mdy;
               msy += mdy;
            end
         end
         mh++;
         if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
         end
      end
   end

   int cyc = 0;
   int last_ft = -1;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_q.size() > 0) check("pix", obs, exp_q.pop_front());
         if (vif.frame_tick) begin
            if (last_ft >= 0) check("ft_period", cyc - last_ft, FR);
            last_ft = cyc;
         end
      end else begin
         check("rst_val", obs, RST_VAL);
         last_ft = -1;
      end
   end

   task automatic wait_pix(input int hp, input int vp);
      int n;
      bit hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < 2 * FR) begin
         @(negedge clk);
         n++;
         if (rst_n && vif.hpos == hp[9:0] && vif.vpos == vp[9:0])
            hit = 1'b1;
      end
      check("wait_pix", {31'b0, hit}, 32'd1);
   endtask

   task automatic at_pix(input string tag, input int hp, input int vp,
                         input logic [5:0] exp);
      wait_pix(hp, vp);
      check(tag, {26'b0, vif.r, vif.g, vif.b}, {26'b0, exp});
   endtask

   initial begin
      vif.mode  = 2'd0;
      vif.pause = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 check("first_px", {11'b0, vif.hpos, vif.vpos, vif.frame_tick},
               {11'b0, 10'd0, 10'd0, 1'b1});

      // colour bars, incl. remainder pixels folded into bar 7
      @(negedge clk) vif.mode = 2'd1;
      wait_pix(0, VA);
      at_pix("bar3", 3, 0, 6'h00);
      at_pix("bar4", 4, 0, 6'h03);
      at_pix("bar7", 28, 0, 6'h3f);
      at_pix("bar_rem", 35, 0, 6'h3f);

      // mode change mid-frame must wait for the blanking line
      vif.mode = 2'd0;
      wait_pix(0, VA);
      wait_pix(0, 5);
      vif.mode = 2'd2;
      at_pix("latch_hold", 0, 6, {2'd1, 2'd2, 2'd0});
      at_pix("chk_black", 0, 0, 6'h00);
      at_pix("chk_white", 4, 0, 6'h3f);

      // bouncing square across both limits, then paused
      vif.mode = 2'd3;
      repeat (36) wait_pix(0, VA);
      vif.pause = 1'b1;
      repeat (10) wait_pix(0, VA);
      vif.pause = 1'b0;
      repeat (2) wait_pix(0, VA);

      // asynchronous reset in the middle of a line
      wait_pix(20, 6);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_rst", obs, RST_VAL);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (3) wait_pix(0, VA);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised VGA timing and test-pattern generator. It replaces the fixed 640x480 border demo with configurable timing and sync polarity, runtime-selectable patterns and an animated bouncing-square mode. It sits directly behind the Tiny VGA Pmod pin mapping in the top level and drives RGB, hsync and vsync.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
CW, 2, bits per colour channel (≥2)
CHK_LOG2, 5, checkerboard cell size = 2^CHK_LOG2 pixels
SQ_SIZE, 32, bouncing-square side in pixels (< V_ACTIVE)

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, asynchronous, active-low
mode  in  2  pattern select: 0 border, 1 colour bars, 2 checkerboard, 3 bouncing square
pause  in  1  freeze square animation
r  out  CW  red
g  out  CW  green
b  out  CW  blue
hsync  out  1  horizontal sync, level per H_POL
vsync  out  1  vertical sync, level per V_POL
display_on  out  1  in visible area
hpos  out  10  x of current output pixel
vpos  out  10  y of current output pixel
frame_tick  out  1  one-cycle pulse with pixel (0,0)

Behaviour:
- Single clock domain, clk; rst_n asynchronous active-low, deassertion used synchronously.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Counters: hc counts 0..H_TOTAL-1 then wraps to 0. vc increments when hc wraps and itself wraps V_TOTAL-1 -> 0.
- All outputs are registered with 1-cycle latency from the counters and are mutually aligned. hpos/vpos are the counter values from the same cycle as r/g/b/sync.
- hsync is at its active level iff H_ACTIVE+H_FP ≤ hpos < H_ACTIVE+H_FP+H_SYNC. vsync is the same on vpos with V parameters, for whole lines.
- display_on = (hpos < H_ACTIVE) && (vpos < V_ACTIVE). r/g/b are all 0 whenever display_on = 0.
- frame_tick = 1 exactly when the output hpos=0 and vpos=0.
- Reset values: hc=vc=0, hpos=vpos=0, r=g=b=0, display_on=0, frame_tick=0, hsync=~H_POL, vsync=~V_POL, square at (0,0) moving +x,+y, active mode 0.
- The first output after reset release is pixel (0,0) with frame_tick=1.
- Mode latch: mode is sampled into the active-mode register only when the counters reach (hc=0, vc=V_ACTIVE), the first blanking line. Mid-frame changes never tear.
- Colour codes: LO = 1, MID = 2^(CW-1), MAX = all ones.
- Mode 0, border:
  - r = LO at hpos=0, MID for hpos<H_ACTIVE-1, MAX at hpos=H_ACTIVE-1.
  - g uses the same rule on vpos/V_ACTIVE.
  - b = 0.
- Mode 1, colour bars:
  - BAR_W = H_ACTIVE>>3; bar index i = hpos/BAR_W, saturated at 7 so remainder pixels join bar 7.
  - r = i[2] ? MAX : 0, g = i[1] ? MAX : 0, b = i[0] ? MAX : 0.
  - No divider: use a running bar counter reset at hc=0.
- Mode 2, checkerboard: white (MAX,MAX,MAX) when hpos[CHK_LOG2] ^ vpos[CHK_LOG2] = 1, else black.
- Mode 3, bouncing square:
  - Pixel is white if sx ≤ hpos < sx+SQ_SIZE and sy ≤ vpos < sy+SQ_SIZE; otherwise background (0,0,MID).
  - sx ranges 0..H_ACTIVE-SQ_SIZE; sy ranges 0..V_ACTIVE-SQ_SIZE.
  - Update once per frame at (hc=0, vc=V_ACTIVE), only if pause=0. For each axis independently, if at the limit in the travel direction, flip direction and step 1 in the new direction; otherwise step 1.
  - The square keeps animating while another mode is displayed.
- A reset asserted mid-frame immediately forces all reset values; no partial-line recovery.

Test Plan:
- Reset, defaults: hold rst_n=0 for 5 cycles then release -> r=g=b=0, hsync=vsync=1 during reset; the first output has hpos=0, vpos=0, frame_tick=1; the next frame_tick comes exactly 420000 cycles later.
- Sync timing, default: hsync=0 for hpos 656..751 (96 clocks) on every line; vsync=0 for vpos 490..491; display_on=0 for hpos≥640 or vpos≥480.
- Mode 1 bars: hpos 79 -> (0,0,0); hpos 80 -> (0,0,3); hpos 560..639 -> (3,3,3). With H_ACTIVE=644, hpos 640..643 stay (3,3,3).
- Mode latch: switch mode 0->2 at vpos=100 -> rest of frame still border; next frame at (32,0) -> white, at (0,0) -> black.
- Bounce: mode 3, pause=0 -> after 608 frame updates sx=608; next update sx=607. After 448 updates sy=448; next sy=447. With pause=1 for 10 frames, sx/sy are unchanged.
- Reset mid-frame: assert rst_n=0 at hpos=300, vpos=200 -> outputs go to reset values asynchronously before the next clk edge; the square returns to (0,0) and the mode to border.
